esc_strip_fifo: RTL and testbench
=================================

ESC_STRIP_FIFO -- requirements
Module: esc_strip_fifo

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-003 SHALL have port: dataIn  input  8  byte from the case-transform stage output.
REQ-004 SHALL have port: inValid  input  1  dataIn holds a byte to offer this cycle.
REQ-005 SHALL have port: inReady  output  1  block accepts the offered byte this cycle.
REQ-006 SHALL have port: dataOut  output  8  head-of-queue text byte.
REQ-007 SHALL have port: outValid  output  1  dataOut is valid.
REQ-008 SHALL have port: outReady  input  1  consumer takes dataOut this cycle.
REQ-009 SHALL have port: count  output  3  number of stored bytes, 0..4.
REQ-010 SHALL have port: badCmd  output  1  sticky flag: an escape was followed by a byte other than L/U/N/C.
REQ-011 SHALL have port: dropCount  output  8  saturating count of stripped bytes.
REQ-012 SHALL use a single clock; reset is synchronous and active-high.

Function
REQ-013 SHALL implement a 4-entry byte FIFO with 2-bit read and write pointers that wrap 3->0.
REQ-014 SHALL define accept = inValid && inReady, with inReady = (count < 4), independent of state.
REQ-015 SHALL define pop = outValid && outReady, with outValid = (count != 0) and dataOut = mem[rdPtr] (no extra latency).
REQ-016 SHALL implement a 2-state FSM: TEXT and ESC.
REQ-017 In TEXT, an accepted byte 8'h1b SHALL be dropped (not stored), increment dropCount, and move the FSM to ESC.
REQ-018 In TEXT, any other accepted byte SHALL be written at wrPtr; wrPtr advances by 1.
REQ-019 In ESC, the next accepted byte SHALL be dropped, increment dropCount, and return the FSM to TEXT; this holds for any value, including 8'h1b.
REQ-020 In ESC, if that byte is not 8'h4c, 8'h55, 8'h4e or 8'h43, badCmd SHALL be set to 1 and held until reset.
REQ-021 Without accept, the FSM SHALL hold its state.
REQ-022 count SHALL change each cycle as follows: +1 on a store without pop; -1 on a pop without store; unchanged on store and pop together, or on neither.
REQ-023 A dropped byte SHALL never change count or wrPtr.
REQ-024 A store and a pop in the same cycle with count in 1..3 SHALL both complete; the popped byte is the old head.
REQ-025 When count==4, inReady SHALL be 0 even if outReady is 1 in the same cycle (no full bypass).
REQ-026 When count==0, dataOut is don't-care; a byte stored in cycle N SHALL appear with outValid=1 in cycle N+1.
REQ-027 dropCount SHALL saturate at 8'hff and never wrap.
REQ-028 Byte order on dataOut SHALL equal the order of stored bytes.

Reset
REQ-029 In a cycle with reset=1, the next state SHALL be: count=0, rdPtr=wrPtr=0, FSM=TEXT, badCmd=0, dropCount=0, outValid=0; inReady=1 from the following cycle.
REQ-030 Reset SHALL take priority over a simultaneous accept or pop. Stored bytes are discarded, and a pending ESC state is cleared.
REQ-031 FIFO memory contents need not be reset.

Verification
REQ-032 Stream 41,1b,4c,62 with outReady=1 -> dataOut sequence 41,62; dropCount=2; badCmd=0.
REQ-033 Stream 1b,1b,63 -> only 63 is output; dropCount=2; badCmd=1 (second 1b is the command byte).
REQ-034 outReady=0, push 5 bytes 30..34 -> count=4 and inReady=0 after the 4th; the 5th is held off; then outReady=1 -> 30,31,32,33,34 in order.
REQ-035 count=2, simultaneous store and pop -> count stays 2; the old head is output; pointers wrap correctly across 3->0.
REQ-036 Send 1b, then assert reset, then 4c -> 4c is stored and output (ESC cleared); dropCount=0 after reset.
REQ-037 Send 300 ESC pairs -> dropCount=ff and stays there; count=0.

Source files
------------

// File: rtl/esc_strip_fifo_if.sv
// esc_strip_fifo_if: handshake bundle for esc_strip_fifo.
//   dataIn/inValid/inReady    : upstream byte stream from the case-transform stage
//   dataOut/outValid/outReady : downstream text-byte stream
//   count, badCmd, dropCount  : status (fill level, sticky bad command, strip count)
// slave  : the FIFO's view of the bundle.
// master : the producer/consumer view of the bundle (testbench or surrounding logic).
interface esc_strip_fifo_if;
    logic [7:0] dataIn;
    logic       inValid;
    logic       inReady;
    logic [7:0] dataOut;
    logic       outValid;
    logic       outReady;
    logic [2:0] count;
    logic       badCmd;
    logic [7:0] dropCount;

    modport slave (
        input  dataIn, inValid, outReady,
        output inReady, dataOut, outValid, count, badCmd, dropCount
    );

    modport master (
        output dataIn, inValid, outReady,
        input  inReady, dataOut, outValid, count, badCmd, dropCount
    );
endinterface

// File: rtl/esc_strip_fifo.sv
// esc_strip_fifo: 4-entry byte FIFO that strips escape sequences (1b xx) from
// the incoming stream. Bytes outside an escape are queued in order; the escape
// byte and the command byte after it are dropped and counted. A command byte
// other than L/U/N/C raises a sticky badCmd flag.
// Ports:
//   clock : sole clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : esc_strip_fifo_if.slave (byte in/out handshakes and status)
module esc_strip_fifo (
    input  logic                  clock,
    input  logic                  reset,
    esc_strip_fifo_if.slave       bus
);
    typedef enum logic {TEXT, ESC} state_t;

    localparam logic [7:0] ESC_BYTE = 8'h1b;

    state_t     state, state_next;
    logic [7:0] mem [4];
    logic [1:0] rd_ptr, wr_ptr;
    logic [2:0] count;
    logic       bad_cmd;
    logic [7:0] drop_count;

    logic accept, pop, store, drop, bad_set;

    // Full means full: a pop in the same cycle does not open a slot.
    assign bus.inReady   = (count < 3'd4);
    assign bus.outValid  = (count != 3'd0);
    assign bus.dataOut   = mem[rd_ptr];
    assign bus.count     = count;
    assign bus.badCmd    = bad_cmd;
    assign bus.dropCount = drop_count;

    assign accept = bus.inValid && bus.inReady;
    assign pop    = bus.outValid && bus.outReady;

    // Decides, for each accepted byte, whether it is stored or stripped.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        store      = 1'b0;
        drop       = 1'b0;
        bad_set    = 1'b0;
        if (accept) begin
            unique case (state)
                TEXT: begin
                    if (bus.dataIn == ESC_BYTE) begin
                        drop       = 1'b1;
                        state_next = ESC;
                    end else begin
                        store = 1'b1;
                    end
                end
                ESC: begin
                    // Command byte is always consumed, even a second 1b.
                    drop       = 1'b1;
                    state_next = TEXT;
                    if (!(bus.dataIn inside {8'h4c, 8'h55, 8'h4e, 8'h43}))
                        bad_set = 1'b1;
                end
                default: state_next = TEXT;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all sequential state so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= TEXT;
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            count      <= 3'd0;
            bad_cmd    <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            state <= state_next;
            if (store) wr_ptr <= wr_ptr + 2'd1;
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
            if (store && !pop)      count <= count + 3'd1;
            else if (pop && !store) count <= count - 3'd1;
            if (bad_set) bad_cmd <= 1'b1;
            if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (store && !reset) mem[wr_ptr] <= bus.dataIn;
    end
endmodule

// File: tb/tb_esc_strip_fifo.sv
// tb_esc_strip_fifo: directed self-checking bench for esc_strip_fifo.
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// in that same window, i.e. they reflect the last edge plus the current inputs.
module tb_esc_strip_fifo;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    esc_strip_fifo_if bus ();

    esc_strip_fifo dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one byte for exactly one edge (accepted if inReady is high).
    task automatic push(input logic [7:0] b);
        bus.dataIn  = b;
        bus.inValid = 1'b1;
        tick();
        bus.inValid = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.inValid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        bus.dataIn   = 8'h00;
        bus.inValid  = 1'b0;
        bus.outReady = 1'b0;
        #2;

        // Reset state
        do_reset();
        check("rst_count",    bus.count,     8'd0);
        check("rst_outValid", bus.outValid,  8'd0);
        check("rst_inReady",  bus.inReady,   8'd1);
        check("rst_badCmd",   bus.badCmd,    8'd0);
        check("rst_drop",     bus.dropCount, 8'd0);

        // Stream 41,1b,4c,62 with outReady=1 -> 41,62
        bus.outReady = 1'b1;
        push(8'h41);
        check("s1_valid41", bus.outValid, 8'd1);
        check("s1_data41",  bus.dataOut,  8'h41);
        push(8'h1b);
        check("s1_cnt_after_esc", bus.count, 8'd0);
        push(8'h4c);
        check("s1_cnt_after_cmd", bus.count, 8'd0);
        push(8'h62);
        check("s1_data62", bus.dataOut, 8'h62);
        check("s1_cnt62",  bus.count,   8'd1);
        tick();
        check("s1_drained", bus.count,     8'd0);
        check("s1_drop",    bus.dropCount, 8'd2);
        check("s1_badCmd",  bus.badCmd,    8'd0);

        // Stream 1b,1b,63 -> 63 only, badCmd set
        do_reset();
        bus.outReady = 1'b1;
        push(8'h1b);
        push(8'h1b);
        check("s2_cnt",    bus.count,     8'd0);
        check("s2_drop",   bus.dropCount, 8'd2);
        check("s2_badCmd", bus.badCmd,    8'd1);
        push(8'h63);
        check("s2_valid63", bus.outValid, 8'd1);
        check("s2_data63",  bus.dataOut,  8'h63);
        tick();
        check("s2_drained",     bus.count,  8'd0);
        check("s2_badCmd_held", bus.badCmd, 8'd1);

        // Fill to 4, no full bypass, drain in order
        do_reset();
        bus.outReady = 1'b0;
        push(8'h30);
        push(8'h31);
        push(8'h32);
        push(8'h33);
        check("s3_full_cnt",     bus.count,   8'd4);
        check("s3_full_inReady", bus.inReady, 8'd0);
        bus.dataIn   = 8'h34;
        bus.inValid  = 1'b1;
        bus.outReady = 1'b1;
        check("s3_no_bypass", bus.inReady, 8'd0);
        check("s3_head30",    bus.dataOut, 8'h30);
        tick();
        check("s3_cnt3",      bus.count,   8'd3);
        check("s3_inReady",   bus.inReady, 8'd1);
        check("s3_head31",    bus.dataOut, 8'h31);
        tick();
        bus.inValid = 1'b0;
        check("s3_cnt_sp",    bus.count,   8'd3);
        check("s3_head32",    bus.dataOut, 8'h32);
        tick();
        check("s3_head33",    bus.dataOut, 8'h33);
        tick();
        check("s3_head34",    bus.dataOut, 8'h34);
        tick();
        check("s3_empty",     bus.count,   8'd0);
        check("s3_outValid",  bus.outValid, 8'd0);

        // count=2 with simultaneous store+pop, pointers wrap 3->0
        bus.outReady = 1'b0;
        push(8'h50);
        push(8'h51);
        check("s4_cnt2", bus.count, 8'd2);
        bus.outReady = 1'b1;
        check("s4_head50", bus.dataOut, 8'h50);
        push(8'h52);
        check("s4_cnt_a",  bus.count,   8'd2);
        check("s4_head51", bus.dataOut, 8'h51);
        push(8'h53);
        check("s4_cnt_b",  bus.count,   8'd2);
        check("s4_head52", bus.dataOut, 8'h52);
        push(8'h54);
        check("s4_cnt_c",  bus.count,   8'd2);
        check("s4_head53", bus.dataOut, 8'h53);
        tick();
        check("s4_head54", bus.dataOut, 8'h54);
        tick();
        check("s4_empty",  bus.count,   8'd0);

        // 1b, then reset (with a competing accept), then 4c is stored
        do_reset();
        bus.outReady = 1'b0;
        push(8'h1b);
        check("s5_drop1", bus.dropCount, 8'd1);
        reset       = 1'b1;
        bus.dataIn  = 8'h77;
        bus.inValid = 1'b1;
        tick();
        reset       = 1'b0;
        bus.inValid = 1'b0;
        check("s5_rst_cnt",  bus.count,     8'd0);
        check("s5_rst_drop", bus.dropCount, 8'd0);
        push(8'h4c);
        check("s5_cnt_4c",  bus.count,     8'd1);
        check("s5_data_4c", bus.dataOut,   8'h4c);
        check("s5_drop0",   bus.dropCount, 8'd0);
        bus.outReady = 1'b1;
        tick();

        // 300 ESC pairs -> dropCount saturates at ff
        do_reset();
        bus.outReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push(8'h1b);
            push(8'h4e);
            if (i == 126) check("s6_drop_fe", bus.dropCount, 8'hfe);
            if (i == 127) check("s6_drop_ff", bus.dropCount, 8'hff);
        end
        check("s6_drop_sat", bus.dropCount, 8'hff);
        check("s6_cnt",      bus.count,     8'd0);
        check("s6_badCmd",   bus.badCmd,    8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
